depacketizer: RTL and testbench

DEPACKETIZER -- requirements
Module: depacketizer

---
 rtl/depacketizer_pkg.sv | 35 +++
 rtl/depacketizer_out_slot.sv | 29 ++
 rtl/depacketizer.sv | 89 ++++++++
 tb/tb_depacketizer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depacketizer_pkg.sv
// Shared field layout and state encoding for the depacketizer.
package depacketizer_pkg;

  // Fixed-position header and control fields
  localparam int unsigned TS_BIT     = 5;
  localparam int unsigned RSVD_A_LO  = 6;
  localparam int unsigned RSVD_A_HI  = 8;
  localparam int unsigned SPK_BIT    = 9;
  localparam int unsigned NODE_LO    = 10;
  localparam int unsigned NODE_HI    = 11;
  localparam int unsigned RSVD_B_LO  = 12;

  // Width-dependent field offsets
  function automatic int unsigned pkt_width(input int unsigned w);
    return 9 + 3 * w;
  endfunction

  function automatic int unsigned rsvd_b_hi(input int unsigned w);
    return 8 + 2 * w;
  endfunction

  function automatic int unsigned res_lo(input int unsigned w);
    return 9 + 2 * w;
  endfunction

  function automatic int unsigned res_hi(input int unsigned w);
    return 8 + 3 * w;
  endfunction

  typedef enum logic {
    IDLE,
    DISPATCH
  } state_t;

endpackage

// File: rtl/depacketizer_out_slot.sv
// Single-entry valid/ready holding register for one output channel.
module depacketizer_out_slot
  import depacketizer_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // Capture on load, hold until the consumer handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/depacketizer.sv
// Splits an incoming packet into independent residue and outspike channels,
// dropping and counting malformed packets.
module depacketizer
  import depacketizer_pkg::*;
#(
  parameter  int unsigned FILTER_WIDTH = 8,
  localparam int unsigned PW           = pkt_width(FILTER_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pkt_valid,
  output logic                    pkt_ready,
  input  logic [PW-1:0]           pkt_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FILTER_WIDTH-1:0] res_data,
  output logic [1:0]              res_node,
  output logic                    res_timestep,
  output logic                    spk_valid,
  input  logic                    spk_ready,
  output logic                    spk_data,
  output logic [1:0]              spk_node,
  output logic                    spk_timestep,
  output logic                    err_flag,
  output logic [7:0]              err_cnt
);

  localparam int unsigned RSVD_B_HI = rsvd_b_hi(FILTER_WIDTH);
  localparam int unsigned RES_LO    = res_lo(FILTER_WIDTH);
  localparam int unsigned RES_HI    = res_hi(FILTER_WIDTH);

  state_t state;
  logic   accept;
  logic   malformed;
  logic   load;
  logic   res_pending;
  logic   spk_pending;

  // Routing header (direction, x-hop, y-hop) is consumed upstream; dropped here
  logic   unused_hdr;
  assign unused_hdr = ^pkt_data[TS_BIT-1:0];

  assign pkt_ready   = (state == IDLE);
  assign accept      = pkt_valid && pkt_ready;
  assign malformed   = (|pkt_data[RSVD_A_HI:RSVD_A_LO]) || (|pkt_data[RSVD_B_HI:RSVD_B_LO]);
  assign load        = accept && !malformed;
  assign res_pending = res_valid && !res_ready;
  assign spk_pending = spk_valid && !spk_ready;

  // Packet FSM plus malformed-packet pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err_flag <= accept && malformed;
      if (accept && malformed && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        IDLE:     if (load) state <= DISPATCH;
        DISPATCH: if (!res_pending && !spk_pending) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  depacketizer_out_slot #(.DW(FILTER_WIDTH + 3)) u_res_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data ({pkt_data[RES_HI:RES_LO], pkt_data[NODE_HI:NODE_LO], pkt_data[TS_BIT]}),
    .ready     (res_ready),
    .valid     (res_valid),
    .data      ({res_data, res_node, res_timestep})
  );

  depacketizer_out_slot #(.DW(4)) u_spk_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data ({pkt_data[SPK_BIT], pkt_data[NODE_HI:NODE_LO], pkt_data[TS_BIT]}),
    .ready     (spk_ready),
    .valid     (spk_valid),
    .data      ({spk_data, spk_node, spk_timestep})
  );

endmodule

// File: tb/tb_depacketizer.sv
// Directed scoreboard bench for depacketizer (FILTER_WIDTH = 8).
module tb_depacketizer;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 9 + 3 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_valid = 1'b0;
  logic          pkt_ready;
  logic [PW-1:0] pkt_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic [1:0]    res_node;
  logic          res_timestep;
  logic          spk_valid;
  logic          spk_ready = 1'b0;
  logic          spk_data;
  logic [1:0]    spk_node;
  logic          spk_timestep;
  logic          err_flag;
  logic [7:0]    err_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [1:0]   n;
    logic         t;
  } res_exp_t;

  typedef struct packed {
    logic       s;
    logic [1:0] n;
    logic       t;
  } spk_exp_t;

  res_exp_t res_q[$];
  spk_exp_t spk_q[$];

  depacketizer #(.FILTER_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_node     (res_node),
    .res_timestep (res_timestep),
    .spk_valid    (spk_valid),
    .spk_ready    (spk_ready),
    .spk_data     (spk_data),
    .spk_node     (spk_node),
    .spk_timestep (spk_timestep),
    .err_flag     (err_flag),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [W-1:0] r, input logic [1:0] n,
                                       input logic t, input logic s, input logic [4:0] hdr);
    return {r, 13'b0, n, s, 3'b000, t, hdr};
  endfunction

  // Drive one packet, push expectations if well-formed, wait (bounded) for accept
  task automatic send(input logic [W-1:0] r, input logic [1:0] n, input logic t,
                      input logic s, input logic [4:0] hdr, input logic [PW-1:0] corrupt,
                      output int acc);
    logic done;
    done = 1'b0;
    acc  = -1;
    if (corrupt == '0) begin
      res_q.push_back('{r: r, n: n, t: t});
      spk_q.push_back('{s: s, n: n, t: t});
    end
    pkt_valid = 1'b1;
    pkt_data  = mk(r, n, t, s, hdr) | corrupt;
    for (int k = 0; k < 40 && !done; k++) begin
      if (pkt_ready) begin
        @(posedge clk);
        #1;
        acc  = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    pkt_valid = 1'b0;
    if (!done) check("accept_timeout", {31'b0, pkt_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_spk_valid"}, {31'b0, spk_valid}, 32'd0);
    check({tag, "_res_data"}, {24'b0, res_data}, 32'd0);
    check({tag, "_res_node"}, {30'b0, res_node}, 32'd0);
    check({tag, "_res_ts"}, {31'b0, res_timestep}, 32'd0);
    check({tag, "_spk_data"}, {31'b0, spk_data}, 32'd0);
    check({tag, "_spk_node"}, {30'b0, spk_node}, 32'd0);
    check({tag, "_spk_ts"}, {31'b0, spk_timestep}, 32'd0);
    check({tag, "_err_flag"}, {31'b0, err_flag}, 32'd0);
    check({tag, "_err_cnt"}, {24'b0, err_cnt}, 32'd0);
    check({tag, "_pkt_ready"}, {31'b0, pkt_ready}, 32'd1);
  endtask

  // Scoreboard: every cycle a channel shows valid, its data must match the head entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (res_q.size() == 0) begin
          check("res_spurious_valid", {31'b0, res_valid}, 32'd0);
        end else begin
          check("res_data", {24'b0, res_data}, {24'b0, res_q[0].r});
          check("res_node", {30'b0, res_node}, {30'b0, res_q[0].n});
          check("res_ts", {31'b0, res_timestep}, {31'b0, res_q[0].t});
          if (res_ready) void'(res_q.pop_front());
        end
      end
      if (spk_valid) begin
        if (spk_q.size() == 0) begin
          check("spk_spurious_valid", {31'b0, spk_valid}, 32'd0);
        end else begin
          check("spk_data", {31'b0, spk_data}, {31'b0, spk_q[0].s});
          check("spk_node", {30'b0, spk_node}, {30'b0, spk_q[0].n});
          check("spk_ts", {31'b0, spk_timestep}, {31'b0, spk_q[0].t});
          if (spk_ready) void'(spk_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int prev;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    check("post_reset_pkt_ready", {31'b0, pkt_ready}, 32'd1);

    // Reference packet 33'h14A000A20, both readies high
    res_ready = 1'b1;
    spk_ready = 1'b1;
    send(8'hA5, 2'd2, 1'b1, 1'b1, 5'b00000, '0, acc);
    check("ref_res_valid", {31'b0, res_valid}, 32'd1);
    check("ref_spk_valid", {31'b0, spk_valid}, 32'd1);
    check("ref_pkt_ready_busy", {31'b0, pkt_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("ref_res_valid_drop", {31'b0, res_valid}, 32'd0);
    check("ref_spk_valid_drop", {31'b0, spk_valid}, 32'd0);
    check("ref_pkt_ready_back", {31'b0, pkt_ready}, 32'd1);

    // Residue stalled 5 cycles; a second packet waits upstream meanwhile
    res_ready = 1'b0;
    send(8'hA5, 2'd2, 1'b1, 1'b1, 5'b10110, '0, acc);
    check("stall_res_valid", {31'b0, res_valid}, 32'd1);
    check("stall_spk_valid", {31'b0, spk_valid}, 32'd1);
    res_q.push_back('{r: 8'h3C, n: 2'd1, t: 1'b0});
    spk_q.push_back('{s: 1'b0, n: 2'd1, t: 1'b0});
    pkt_valid = 1'b1;
    pkt_data  = mk(8'h3C, 2'd1, 1'b0, 1'b0, 5'b01011);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      res_ready = (i == 2);
      check("stall_res_held", {31'b0, res_valid}, 32'd1);
      check("stall_spk_done", {31'b0, spk_valid}, 32'd0);
      check("stall_pkt_ready", {31'b0, pkt_ready}, 32'd0);
      res_ready = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_res_done", {31'b0, res_valid}, 32'd0);
    check("stall_pkt_ready_back", {31'b0, pkt_ready}, 32'd1);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    check("held_pkt_res_valid", {31'b0, res_valid}, 32'd1);
    check("held_pkt_spk_valid", {31'b0, spk_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Malformed packets: reserved low bits, reserved mid bit, top reserved bit
    send(8'hA5, 2'd2, 1'b1, 1'b1, 5'b00000, 33'h40, acc);
    check("mal_err_flag", {31'b0, err_flag}, 32'd1);
    check("mal_err_cnt", {24'b0, err_cnt}, 32'd1);
    check("mal_res_valid", {31'b0, res_valid}, 32'd0);
    check("mal_spk_valid", {31'b0, spk_valid}, 32'd0);
    check("mal_pkt_ready", {31'b0, pkt_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("mal_err_flag_drop", {31'b0, err_flag}, 32'd0);
    check("mal_err_cnt_hold", {24'b0, err_cnt}, 32'd1);
    send(8'h11, 2'd3, 1'b0, 1'b1, 5'b11111, 33'h100000, acc);
    send(8'h22, 2'd0, 1'b1, 1'b0, 5'b00001, 33'h1000000, acc);
    check("mal_err_cnt_3", {24'b0, err_cnt}, 32'd3);
    // Lowest residue bit set is legal
    send(8'h01, 2'd1, 1'b1, 1'b0, 5'b00000, '0, acc);
    check("legal_res_lsb_err_flag", {31'b0, err_flag}, 32'd0);
    check("legal_res_lsb_err_cnt", {24'b0, err_cnt}, 32'd3);
    @(posedge clk);
    #1;

    // Back-to-back with readies high: one accept every 2 cycles
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h10 + 8'(i * 37)), 2'(i), 1'(i), 1'(i + 1), 5'(i * 7), '0, acc);
      if (prev >= 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    repeat (2) @(posedge clk);
    #1;

    // Counter saturation
    for (int i = 0; i < 260; i++) begin
      send(8'h5A, 2'd1, 1'b0, 1'b1, 5'b00000, 33'h80, acc);
    end
    check("sat_err_cnt", {24'b0, err_cnt}, 32'd255);
    check("sat_err_flag", {31'b0, err_flag}, 32'd1);
    @(posedge clk);
    #1;
    check("sat_err_cnt_hold", {24'b0, err_cnt}, 32'd255);

    // Asynchronous reset while a packet is being dispatched
    res_ready = 1'b0;
    spk_ready = 1'b0;
    send(8'hC3, 2'd3, 1'b1, 1'b1, 5'b00000, '0, acc);
    check("rst_pre_res_valid", {31'b0, res_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    res_q.delete();
    spk_q.delete();
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_release_pkt_ready", {31'b0, pkt_ready}, 32'd1);
    res_ready = 1'b1;
    spk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_stale_res", {31'b0, res_valid}, 32'd0);
      check("rst_no_stale_spk", {31'b0, spk_valid}, 32'd0);
    end

    check("res_q_drained", 32'(res_q.size()), 32'd0);
    check("spk_q_drained", 32'(spk_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
